// File: rtl/pam4_tx_serializer.sv
// PAM4 transmit serializer: frames parallel words into 2-bit symbols, one per sym_clk period.
// Each frame is an optional 3,0,3,0... preamble followed by the word's bit pairs, MSB pair first.
module pam4_tx_serializer #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned PRE_LEN = 4,
  parameter int unsigned GRAY    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sym_clk,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [1:0]        sym_out,
  output logic              sym_valid,
  output logic              frame_start,
  output logic              busy
);

  localparam int unsigned NumSym = DATA_W / 2;
  localparam int unsigned CntMax = ((PRE_LEN > NumSym) ? PRE_LEN : NumSym) + 1;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] PreLast  = CntW'(PRE_LEN);
  localparam logic [CntW-1:0] DataLast = CntW'(NumSym - 1);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);

  typedef enum logic [1:0] {StIdle, StArmed, StPre, StData} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              sym_clk_q;
  logic [1:0]        sym_out_q, sym_out_d;
  logic              sym_valid_q, sym_valid_d;
  logic              frame_start_q, frame_start_d;

  logic              tick;
  logic [1:0]        data_sym;
  logic [DATA_W-1:0] shift_nxt;
  state_e            after_first_data;

  function automatic logic [1:0] code_pair(input logic [1:0] pair);
    if (GRAY != 0) begin
      return {pair[1], pair[1] ^ pair[0]};
    end
    return pair;
  endfunction

  always_comb begin
    tick             = sym_clk & ~sym_clk_q;
    data_sym         = code_pair(shift_q[DATA_W-1 -: 2]);
    shift_nxt        = shift_q << 2;
    // A one-symbol word is finished as soon as its only symbol is launched.
    after_first_data = (NumSym == 1) ? StIdle : StData;

    state_d       = state_q;
    cnt_d         = cnt_q;
    shift_d       = shift_q;
    sym_out_d     = sym_out_q;
    sym_valid_d   = sym_valid_q;
    frame_start_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (tick) begin
          sym_out_d   = 2'd0;
          sym_valid_d = 1'b0;
        end
        if (s_valid) begin
          shift_d = s_data;
          state_d = StArmed;
        end
      end

      StArmed: begin
        if (tick) begin
          if (sym_valid_q) begin
            // Previous frame's last symbol is still showing: insert one idle period first.
            sym_out_d   = 2'd0;
            sym_valid_d = 1'b0;
          end else begin
            frame_start_d = 1'b1;
            sym_valid_d   = 1'b1;
            cnt_d         = CntOne;
            if (PRE_LEN > 0) begin
              sym_out_d = 2'd3;
              state_d   = StPre;
            end else begin
              sym_out_d = data_sym;
              shift_d   = shift_nxt;
              state_d   = after_first_data;
            end
          end
        end
      end

      StPre: begin
        if (tick) begin
          if (cnt_q == PreLast) begin
            sym_out_d = data_sym;
            shift_d   = shift_nxt;
            cnt_d     = CntOne;
            state_d   = after_first_data;
          end else begin
            sym_out_d = cnt_q[0] ? 2'd0 : 2'd3;
            cnt_d     = cnt_q + CntOne;
          end
        end
      end

      StData: begin
        if (tick) begin
          sym_out_d = data_sym;
          shift_d   = shift_nxt;
          if (cnt_q == DataLast) begin
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      shift_q       <= '0;
      sym_clk_q     <= 1'b1;
      sym_out_q     <= 2'd0;
      sym_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shift_q       <= shift_d;
      sym_clk_q     <= sym_clk;
      sym_out_q     <= sym_out_d;
      sym_valid_q   <= sym_valid_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign s_ready     = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign sym_out     = sym_out_q;
  assign sym_valid   = sym_valid_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_pam4_tx_serializer.sv
// Bench for pam4_tx_serializer: three configurations share clk/rst/sym_clk and are checked
// every cycle against a frame-list reference model.
module tb_pam4_tx_serializer;

  localparam int NDut = 3;
  localparam int Div  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sym_clk = 1'b0;
  logic [15:0] sd   [NDut];
  logic        sv_in[NDut];
  logic [1:0]  so   [NDut];
  logic        svo  [NDut];
  logic        sr   [NDut];
  logic        fs   [NDut];
  logic        bz   [NDut];

  int dw  [NDut] = '{16, 16, 2};
  int pl  [NDut] = '{4, 4, 0};
  int gr  [NDut] = '{0, 1, 0};
  int glut[4]    = '{0, 1, 3, 2};

  // Reference model: each accepted word becomes a list of levels consumed one per tick.
  int   frm     [NDut][16];
  int   frm_len [NDut];
  int   frm_pos [NDut];
  bit   m_armed [NDut];
  bit   m_valid [NDut];
  bit   m_fs    [NDut];
  bit   m_acc   [NDut];
  int   m_out   [NDut];
  logic m_symd;
  int   div_cnt;

  bit cap_en;
  int cap    [NDut][16];
  int cap_n  [NDut];
  int fs_cnt [NDut];
  int acc_n  [NDut];

  int n_cmp = 0;
  int n_bad = 0;

  pam4_tx_serializer #(.DATA_W(16), .PRE_LEN(4), .GRAY(0)) u_dut0 (
    .clk(clk), .rst(rst), .sym_clk(sym_clk), .s_data(sd[0]), .s_valid(sv_in[0]),
    .s_ready(sr[0]), .sym_out(so[0]), .sym_valid(svo[0]), .frame_start(fs[0]), .busy(bz[0])
  );
  pam4_tx_serializer #(.DATA_W(16), .PRE_LEN(4), .GRAY(1)) u_dut1 (
    .clk(clk), .rst(rst), .sym_clk(sym_clk), .s_data(sd[1]), .s_valid(sv_in[1]),
    .s_ready(sr[1]), .sym_out(so[1]), .sym_valid(svo[1]), .frame_start(fs[1]), .busy(bz[1])
  );
  pam4_tx_serializer #(.DATA_W(2), .PRE_LEN(0), .GRAY(0)) u_dut2 (
    .clk(clk), .rst(rst), .sym_clk(sym_clk), .s_data(sd[2][1:0]), .s_valid(sv_in[2]),
    .s_ready(sr[2]), .sym_out(so[2]), .sym_valid(svo[2]), .frame_start(fs[2]), .busy(bz[2])
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit m_busy(input int d);
    return m_armed[d] || (frm_pos[d] < frm_len[d]);
  endfunction

  task automatic model_step(input int d, input bit tick);
    int v;
    m_fs[d]  = 1'b0;
    m_acc[d] = 1'b0;
    if (rst) begin
      frm_len[d] = 0;
      frm_pos[d] = 0;
      m_armed[d] = 1'b0;
      m_valid[d] = 1'b0;
      m_out[d]   = 0;
    end else if (!m_busy(d)) begin
      if (tick) begin
        m_out[d]   = 0;
        m_valid[d] = 1'b0;
      end
      if (sv_in[d]) begin
        frm_len[d] = 0;
        frm_pos[d] = 0;
        for (int i = 0; i < pl[d]; i++) begin
          frm[d][frm_len[d]] = (i % 2 == 0) ? 3 : 0;
          frm_len[d]++;
        end
        for (int k = 0; k < dw[d] / 2; k++) begin
          v = int'((sd[d] >> (dw[d] - 2 - 2 * k)) & 16'd3);
          if (gr[d] != 0) v = glut[v];
          frm[d][frm_len[d]] = v;
          frm_len[d]++;
        end
        m_armed[d] = 1'b1;
        m_acc[d]   = 1'b1;
      end
    end else if (m_armed[d]) begin
      if (tick) begin
        if (m_valid[d]) begin
          m_out[d]   = 0;
          m_valid[d] = 1'b0;
        end else begin
          m_out[d]   = frm[d][frm_pos[d]];
          frm_pos[d]++;
          m_valid[d] = 1'b1;
          m_fs[d]    = 1'b1;
          m_armed[d] = 1'b0;
        end
      end
    end else if (tick) begin
      m_out[d] = frm[d][frm_pos[d]];
      frm_pos[d]++;
    end
  endtask

  task automatic cycle();
    bit tick;
    tick = sym_clk & ~m_symd;
    for (int d = 0; d < NDut; d++) model_step(d, tick);
    m_symd = rst ? 1'b1 : sym_clk;
    @(posedge clk);
    #1;
    for (int d = 0; d < NDut; d++) begin
      chk($sformatf("d%0d_sym_out", d), 8'(so[d]), 8'(m_out[d]));
      chk($sformatf("d%0d_sym_valid", d), 8'(svo[d]), 8'(m_valid[d]));
      chk($sformatf("d%0d_frame_start", d), 8'(fs[d]), 8'(m_fs[d]));
      chk($sformatf("d%0d_busy", d), 8'(bz[d]), 8'(m_busy(d)));
      chk($sformatf("d%0d_s_ready", d), 8'(sr[d]), 8'(!m_busy(d)));
      if (fs[d] === 1'b1) fs_cnt[d]++;
      if (cap_en && tick && !rst && svo[d] === 1'b1 && cap_n[d] < 16) begin
        cap[d][cap_n[d]] = int'(so[d]);
        cap_n[d]++;
      end
    end
    div_cnt = (div_cnt + 1) % Div;
    sym_clk = (div_cnt >= Div / 2);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic send_all();
    for (int d = 0; d < NDut; d++) sv_in[d] = 1'b1;
    for (int n = 0; n < 40 && (sv_in[0] | sv_in[1] | sv_in[2]); n++) begin
      cycle();
      for (int d = 0; d < NDut; d++) if (m_acc[d]) sv_in[d] = 1'b0;
    end
    for (int d = 0; d < NDut; d++) begin
      chk($sformatf("d%0d_accept_bound", d), 8'(sv_in[d]), 8'd0);
      sv_in[d] = 1'b0;
    end
  endtask

  initial begin : stim
    int e0[12];
    int e1[12];
    bit found;
    e0 = '{3, 0, 3, 0, 2, 3, 1, 0, 3, 2, 0, 1};
    e1 = '{3, 0, 3, 0, 3, 2, 1, 0, 2, 3, 0, 1};
    m_symd  = 1'b1;
    div_cnt = 0;
    cap_en  = 1'b0;
    for (int d = 0; d < NDut; d++) begin
      sd[d] = '0; sv_in[d] = 1'b0; frm_len[d] = 0; frm_pos[d] = 0; m_armed[d] = 1'b0;
      m_valid[d] = 1'b0; m_fs[d] = 1'b0; m_acc[d] = 1'b0; m_out[d] = 0;
      cap_n[d] = 0; fs_cnt[d] = 0; acc_n[d] = 0;
    end

    // Reset, then idle with s_ready high.
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    run(4);

    // Known frames: 0xB4E1 binary/Gray with preamble, 2'b10 with no preamble.
    sd[0] = 16'hB4E1; sd[1] = 16'hB4E1; sd[2] = 16'h0002;
    cap_en = 1'b1;
    send_all();
    run(70);
    cap_en = 1'b0;
    chk("d0_sym_count", 8'(cap_n[0]), 8'd12);
    chk("d1_sym_count", 8'(cap_n[1]), 8'd12);
    chk("d2_sym_count", 8'(cap_n[2]), 8'd1);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("d0_seq%0d", i), 8'(cap[0][i]), 8'(e0[i]));
      chk($sformatf("d1_seq%0d", i), 8'(cap[1][i]), 8'(e1[i]));
    end
    chk("d2_seq0", 8'(cap[2][0]), 8'd2);
    for (int d = 0; d < NDut; d++) chk($sformatf("d%0d_fs_count", d), 8'(fs_cnt[d]), 8'd1);

    // Accept in a tick-high idle cycle.
    found = 1'b0;
    for (int n = 0; n < 8 && !found; n++) begin
      if (sym_clk && !m_symd) found = 1'b1;
      else cycle();
    end
    chk("tick_align_bound", 8'(found), 8'd1);
    for (int d = 0; d < NDut; d++) begin
      sd[d] = 16'($urandom);
      sv_in[d] = 1'b1;
    end
    cycle();
    for (int d = 0; d < NDut; d++) sv_in[d] = 1'b0;
    run(70);

    // Back-to-back words with s_valid held high.
    for (int d = 0; d < NDut; d++) begin
      sd[d] = 16'hFFFF;
      sv_in[d] = 1'b1;
      acc_n[d] = 0;
    end
    for (int n = 0; n < 300 && (sv_in[0] | sv_in[1] | sv_in[2]); n++) begin
      cycle();
      for (int d = 0; d < NDut; d++) begin
        if (m_acc[d]) begin
          acc_n[d]++;
          if (acc_n[d] == 1) sd[d] = 16'h0000;
          else sv_in[d] = 1'b0;
        end
      end
    end
    for (int d = 0; d < NDut; d++) begin
      chk($sformatf("d%0d_b2b_accepts", d), 8'(acc_n[d]), 8'd2);
      sv_in[d] = 1'b0;
    end
    run(70);

    // Reset during the third data symbol of dut0, then a fresh frame.
    for (int d = 0; d < NDut; d++) sd[d] = 16'($urandom);
    send_all();
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      if (!m_armed[0] && (frm_len[0] - frm_pos[0]) == 5) found = 1'b1;
      else cycle();
    end
    chk("reach_third_data", 8'(found), 8'd1);
    run(1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    run(6);
    for (int d = 0; d < NDut; d++) sd[d] = 16'($urandom);
    send_all();
    run(70);

    // Random traffic with rare resets.
    for (int n = 0; n < 600; n++) begin
      for (int d = 0; d < NDut; d++) begin
        sv_in[d] = ($urandom_range(0, 2) == 0);
        sd[d]    = 16'($urandom);
      end
      rst = ($urandom_range(0, 249) == 0);
      cycle();
    end
    rst = 1'b0;
    for (int d = 0; d < NDut; d++) sv_in[d] = 1'b0;
    run(70);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
